// File: rtl/uart_tx_param_pkg.sv
// Shared definitions for the parametrised UART transmitter and its input FIFO.
// Holds the parity mode codes, the frame FSM encoding and a constant clog2 helper.
package uart_tx_param_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  // Bits needed to hold values 0..value-1 (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small show-ahead FIFO: rd_data always presents the head entry while not empty.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
module uart_tx_fifo
  import uart_tx_param_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    wr_en,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    rd_en,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    empty,
  output logic                    full,
  output logic [clog2(DEPTH):0]   count
);

  localparam int AW = clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // A write while full is dropped even if a read frees a slot this cycle.
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter with elaboration-time frame format and a queued input FIFO.
// Frames go out back-to-back while words are queued; the line idles high otherwise.
module uart_tx_param
  import uart_tx_param_pkg::*;
#(
  parameter int CLK_DIV    = 10416,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] in,
  input  logic                 en,
  output logic                 full,
  output logic                 out,
  output logic                 busy
);

  localparam int             CW        = clog2(CLK_DIV);
  localparam int             AW        = clog2(FIFO_DEPTH);
  localparam logic [CW-1:0]  DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic           ODD_INV   = (PARITY == PAR_ODD);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("uart_tx_param: CLK_DIV must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_par
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 out_q, out_d;
  logic                 tick;
  logic                 load;
  logic                 pop;
  logic [DATA_BITS-1:0] fifo_data;
  logic                 fifo_empty;
  logic [AW:0]          fifo_count;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (en),
    .wr_data (in),
    .rd_en   (pop),
    .rd_data (fifo_data),
    .empty   (fifo_empty),
    .full    (full),
    .count   (fifo_count)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      out_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      out_q   <= out_d;
    end
  end

  // Every bit is timed by one down-counter reloaded at each bit boundary.
  assign tick = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? DIV_LAST : cnt_q - CW'(1);
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    out_d   = out_q;
    load    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        out_d = 1'b1;
        cnt_d = '0;
        load  = !fifo_empty;
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          out_d   = shreg_q[0];
          shreg_d = shreg_q >> 1;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q == DATA_LAST) begin
            idx_d = '0;
            if (PARITY != PAR_NONE) begin
              state_d = PAR;
              out_d   = par_q;
            end else begin
              state_d = STOP;
              out_d   = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 4'd1;
            out_d   = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end
      end
      PAR: begin
        if (tick) begin
          state_d = STOP;
          out_d   = 1'b1;
          idx_d   = '0;
        end
      end
      STOP: begin
        if (tick) begin
          if (idx_q == STOP_LAST) begin
            if (!fifo_empty) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
              idx_d   = '0;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        out_d   = 1'b1;
      end
    endcase
    // Latch the head word and its parity at pop so later writes cannot disturb the frame.
    if (load) begin
      pop     = 1'b1;
      shreg_d = fifo_data;
      par_d   = (^fifo_data) ^ ODD_INV;
      out_d   = 1'b0;
      cnt_d   = DIV_LAST;
      idx_d   = '0;
      state_d = START;
    end
  end

  assign out  = out_q;
  assign busy = (state_q != IDLE) | (fifo_count != '0);

endmodule
